// File: rtl/ex_operand_stage.sv
// ID/EX operand register feeding the ALU: valid/ready capture, EX/WB forwarding
// at capture, and writeback refresh of held operands while downstream stalls.

module ex_operand_fwd #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] rs,
  input  logic [XLEN-1:0]  rs_val,
  input  logic [RADDR-1:0] held_rs,
  input  logic             ex_valid,
  input  logic             ex_reg_write,
  input  logic [RADDR-1:0] ex_rd,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             wb_we,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  fwd_val,
  output logic             held_wb_hit
);
  logic ex_hit, wb_hit;

  always_comb begin
    ex_hit      = ex_valid && ex_reg_write && (ex_rd == rs) && (rs != '0);
    wb_hit      = wb_we && (wb_rd == rs) && (rs != '0);
    // EX result is younger than writeback, so it wins on a double hit
    fwd_val     = ex_hit ? alu_result : (wb_hit ? wb_data : rs_val);
    held_wb_hit = wb_we && (wb_rd == held_rs) && (held_rs != '0);
  end
endmodule

module ex_operand_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_use_imm,
  input  logic [2:0]       id_alu_sel,
  input  logic [RADDR-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             flush,
  input  logic             ex_ready,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             wb_we,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             ex_valid,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_sel,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_reg_write
);
  localparam int NUM_SRC = 2;

  logic                             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]                  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]                       alu_sel_q, alu_sel_d;
  logic [RADDR-1:0]                 ex_rd_q, ex_rd_d;
  logic                             ex_reg_write_q, ex_reg_write_d;
  logic [NUM_SRC-1:0][RADDR-1:0]    rs_q, rs_d;
  logic                             use_imm_q, use_imm_d;

  logic [NUM_SRC-1:0][RADDR-1:0]    src_idx;
  logic [NUM_SRC-1:0][XLEN-1:0]     src_val, fwd_val;
  logic [NUM_SRC-1:0]               held_hit;
  logic                             capture, stall;

  assign src_idx = {id_rs2, id_rs1};
  assign src_val = {id_rs2_val, id_rs1_val};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      ex_operand_fwd #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd (
        .rs          (src_idx[g]),
        .rs_val      (src_val[g]),
        .held_rs     (rs_q[g]),
        .ex_valid    (ex_valid_q),
        .ex_reg_write(ex_reg_write_q),
        .ex_rd       (ex_rd_q),
        .alu_result  (alu_result),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .fwd_val     (fwd_val[g]),
        .held_wb_hit (held_hit[g])
      );
    end
  endgenerate

  assign id_ready = !ex_valid_q || ex_ready;
  assign capture  = id_valid && id_ready && !flush;
  assign stall    = ex_valid_q && !ex_ready && !flush;

  always_comb begin
    ex_valid_d     = ex_valid_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_sel_d      = alu_sel_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    rs_d           = rs_q;
    use_imm_d      = use_imm_q;

    if (flush)         ex_valid_d = 1'b0;
    else if (capture)  ex_valid_d = 1'b1;
    else if (ex_ready) ex_valid_d = 1'b0;

    if (capture) begin
      alu_a_d        = fwd_val[0];
      alu_b_d        = id_use_imm ? id_imm : fwd_val[1];
      alu_sel_d      = id_alu_sel;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_reg_write;
      rs_d           = src_idx;
      use_imm_d      = id_use_imm;
    end else if (stall) begin
      // Writeback landing during a stall would otherwise leave a stale operand
      if (held_hit[0])               alu_a_d = wb_data;
      if (held_hit[1] && !use_imm_q) alu_b_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_sel_q      <= 3'b000;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      rs_q           <= '0;
      use_imm_q      <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_sel_q      <= alu_sel_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      rs_q           <= rs_d;
      use_imm_q      <= use_imm_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: capture, forwarding priority, x0,
// stall refresh, flush and reset, all with hand-computed expectations.

module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd, ex_rd;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm, alu_result, wb_data, alu_a, alu_b;
  logic        id_use_imm, id_reg_write, flush, ex_ready, wb_we, ex_valid, ex_reg_write;
  logic [2:0]  id_alu_sel, alu_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_sel(id_alu_sel),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .flush(flush), .ex_ready(ex_ready), .alu_result(alu_result),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [31:0] v1,
                       input logic [4:0] rs2, input logic [31:0] v2,
                       input logic use_imm, input logic [31:0] imm,
                       input logic [2:0] sel, input logic [4:0] rd, input logic rw);
    id_valid = 1'b1; id_rs1 = rs1; id_rs1_val = v1; id_rs2 = rs2; id_rs2_val = v2;
    id_use_imm = use_imm; id_imm = imm; id_alu_sel = sel; id_rd = rd; id_reg_write = rw;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_we = we; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1; alu_result = '0;
    set_wb(1'b0, 5'd0, 32'h0);
    offer(5'd1, 32'h5, 5'd2, 32'h7, 1'b0, 32'h0, 3'b010, 5'd0, 1'b0);
    #2;
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_sel", {29'b0, alu_sel}, 32'h0);
    chk("rst_id_ready", {31'b0, id_ready}, 32'h1);
    tick();
    chk("rst_no_capture", {31'b0, ex_valid}, 32'h0);
    reset = 1'b0;

    // Basic capture, offer still pending from above
    tick();
    chk("cap_valid", {31'b0, ex_valid}, 32'h1);
    chk("cap_a", alu_a, 32'h5);
    chk("cap_b", alu_b, 32'h7);
    chk("cap_sel", {29'b0, alu_sel}, 32'h2);

    // EX forward, then EX beating WB on the same index
    offer(5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0, 3'b000, 5'd3, 1'b1);
    tick();
    chk("a_rd", {27'b0, ex_rd}, 32'h3);
    alu_result = 32'h10;
    offer(5'd3, 32'h99, 5'd0, 32'h0, 1'b0, 32'h0, 3'b011, 5'd3, 1'b1);
    tick();
    chk("ex_fwd_a", alu_a, 32'h10);
    chk("ex_fwd_sel", {29'b0, alu_sel}, 32'h3);
    set_wb(1'b1, 5'd3, 32'h20);
    offer(5'd3, 32'h99, 5'd5, 32'h1234, 1'b0, 32'h0, 3'b001, 5'd0, 1'b0);
    tick();
    chk("ex_over_wb_a", alu_a, 32'h10);
    chk("no_fwd_b", alu_b, 32'h1234);

    // WB forward on rs2, then immediate overriding it
    set_wb(1'b1, 5'd4, 32'hAA);
    offer(5'd1, 32'h11, 5'd4, 32'h44, 1'b0, 32'h0, 3'b010, 5'd0, 1'b0);
    tick();
    chk("wb_fwd_b", alu_b, 32'hAA);
    chk("wb_fwd_a_none", alu_a, 32'h11);
    offer(5'd1, 32'h11, 5'd4, 32'h44, 1'b1, 32'hFFFF_FFF0, 3'b110, 5'd0, 1'b1);
    tick();
    chk("imm_b", alu_b, 32'hFFFF_FFF0);

    // x0: held instr writes rd=0 and WB writes x0; neither may forward
    alu_result = 32'h66;
    set_wb(1'b1, 5'd0, 32'h55);
    offer(5'd0, 32'h0, 5'd0, 32'h3, 1'b0, 32'h0, 3'b010, 5'd0, 1'b0);
    tick();
    chk("x0_a", alu_a, 32'h0);
    chk("x0_b", alu_b, 32'h3);
    set_wb(1'b0, 5'd0, 32'h0);

    // Stall with refresh of held rs1
    offer(5'd6, 32'h60, 5'd7, 32'h70, 1'b0, 32'h0, 3'b010, 5'd0, 1'b0);
    tick();
    chk("stall_cap_a", alu_a, 32'h60);
    ex_ready = 1'b0;
    offer(5'd1, 32'hAB, 5'd2, 32'hCD, 1'b0, 32'h0, 3'b101, 5'd0, 1'b0);
    #1;
    chk("stall_id_ready", {31'b0, id_ready}, 32'h0);
    tick();
    chk("stall1_valid", {31'b0, ex_valid}, 32'h1);
    chk("stall1_a", alu_a, 32'h60);
    chk("stall1_sel", {29'b0, alu_sel}, 32'h2);
    set_wb(1'b1, 5'd6, 32'h77);
    tick();
    chk("stall2_refresh_a", alu_a, 32'h77);
    chk("stall2_b", alu_b, 32'h70);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("stall3_a", alu_a, 32'h77);
    chk("stall3_valid", {31'b0, ex_valid}, 32'h1);
    ex_ready = 1'b1;
    #1;
    chk("release_id_ready", {31'b0, id_ready}, 32'h1);
    tick();
    chk("release_cap_a", alu_a, 32'hAB);
    chk("release_cap_sel", {29'b0, alu_sel}, 32'h5);

    // Held use_imm blocks refresh of alu_b
    offer(5'd9, 32'h90, 5'd7, 32'h70, 1'b1, 32'h1, 3'b000, 5'd0, 1'b0);
    tick();
    ex_ready = 1'b0; id_valid = 1'b0;
    set_wb(1'b1, 5'd7, 32'h99);
    tick();
    chk("imm_no_refresh_b", alu_b, 32'h1);
    chk("imm_no_refresh_a", alu_a, 32'h90);
    set_wb(1'b0, 5'd0, 32'h0);
    ex_ready = 1'b1;

    // Drain without capture: valid drops, payload stays
    tick();
    chk("drain_valid", {31'b0, ex_valid}, 32'h0);
    chk("drain_a", alu_a, 32'h90);

    // Flush beats a pending offer
    offer(5'd1, 32'h31, 5'd2, 32'h32, 1'b0, 32'h0, 3'b011, 5'd8, 1'b1);
    tick();
    chk("pre_flush_valid", {31'b0, ex_valid}, 32'h1);
    flush = 1'b1;
    offer(5'd1, 32'hEE, 5'd2, 32'hEF, 1'b0, 32'h0, 3'b111, 5'd9, 1'b1);
    tick();
    chk("flush_valid", {31'b0, ex_valid}, 32'h0);
    chk("flush_a", alu_a, 32'h31);
    chk("flush_sel", {29'b0, alu_sel}, 32'h3);
    chk("flush_rd", {27'b0, ex_rd}, 32'h8);
    flush = 1'b0; id_valid = 1'b0;

    // Reset in the middle of a stall
    offer(5'd1, 32'h41, 5'd2, 32'h42, 1'b0, 32'h0, 3'b110, 5'd10, 1'b1);
    tick();
    ex_ready = 1'b0; id_valid = 1'b0;
    tick();
    chk("pre_rst_valid", {31'b0, ex_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("mid_rst_a", alu_a, 32'h0);
    chk("mid_rst_b", alu_b, 32'h0);
    chk("mid_rst_sel", {29'b0, alu_sel}, 32'h0);
    chk("mid_rst_rd", {27'b0, ex_rd}, 32'h0);
    chk("mid_rst_rw", {31'b0, ex_reg_write}, 32'h0);
    chk("mid_rst_id_ready", {31'b0, id_ready}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
